// File: rtl/i2c_rd_seq.sv
// Random-read sequencer for an I2C EEPROM-style device: writes the word address,
// restarts in read mode and streams len bytes from the byte-level I2C engine.
module i2c_rd_seq #(
  parameter logic [7:0]  DEV_ADDR = 8'hA0,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] addr,
  input  logic [4:0] len,
  output logic       busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       err,
  output logic [7:0] data,
  output logic [1:0] en,
  input  logic [2:0] st,
  input  logic [7:0] out_i2c
);

  localparam int unsigned WD_W    = 16;
  localparam int unsigned LEN_W   = 5;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(16);

  localparam logic [1:0] EN_WR   = 2'd0;
  localparam logic [1:0] EN_RD   = 2'd1;
  localparam logic [1:0] EN_STOP = 2'd2;

  localparam logic [2:0] ST_Z    = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_ACK  = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_STOP = 3'd4;

  typedef enum logic [3:0] {
    IDLE, DEV_W, ACK_W, WADDR, STOP_W, DEV_R, RD, NEXT, LAST, RD_LAST, DONE
  } state_t;

  state_t           state;
  logic [7:0]       addr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] n;
  logic [LEN_W-1:0] n_inc;
  logic [WD_W-1:0]  wd;

  assign n_inc = n + LEN_W'(1);

  // Sequencer; every transition clears the watchdog, which otherwise counts in non-IDLE states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_data  <= 8'h00;
      data     <= 8'h00;
      en       <= EN_STOP;
      addr_q   <= 8'h00;
      len_q    <= '0;
      n        <= '0;
      wd       <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wd       <= (state == IDLE) ? '0 : wd + WD_W'(1);
      if (state != IDLE && wd == WD_LAST) begin
        en    <= EN_STOP;
        done  <= 1'b1;
        err   <= 1'b1;
        busy  <= 1'b0;
        state <= IDLE;
        wd    <= '0;
      end else begin
        case (state)
          IDLE: if (req) begin
            if (len != '0 && len <= MAX_LEN) begin
              addr_q <= addr;
              len_q  <= len;
              n      <= '0;
              data   <= DEV_ADDR;
              en     <= EN_WR;
              busy   <= 1'b1;
              state  <= DEV_W;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
          DEV_W: if (st == ST_WR) begin
            state <= ACK_W;
            wd    <= '0;
          end
          ACK_W: if (st == ST_ACK) begin
            data  <= addr_q;
            state <= WADDR;
            wd    <= '0;
          end
          WADDR: if (st == ST_WR) begin
            en    <= EN_STOP;
            state <= STOP_W;
            wd    <= '0;
          end
          STOP_W: if (st == ST_STOP) begin
            data  <= DEV_ADDR | 8'h01;
            en    <= EN_RD;
            state <= DEV_R;
            wd    <= '0;
          end
          DEV_R: if (st == ST_WR) begin
            wd <= '0;
            if (len_q > LEN_W'(1)) begin
              state <= RD;
            end else begin
              en    <= EN_STOP;
              state <= RD_LAST;
            end
          end
          RD: if (st == ST_Z) begin
            rd_data  <= out_i2c;
            rd_valid <= 1'b1;
            n        <= n_inc;
            wd       <= '0;
            state    <= (n_inc == len_q - LEN_W'(1)) ? LAST : NEXT;
          end
          // Wait out the rest of the Z phase so one phase gives one byte
          NEXT: if (st != ST_Z) begin
            state <= RD;
            wd    <= '0;
          end
          LAST: if (st == ST_RD) begin
            en    <= EN_STOP;
            state <= RD_LAST;
            wd    <= '0;
          end
          RD_LAST: if (st == ST_STOP) begin
            rd_data  <= out_i2c;
            rd_valid <= 1'b1;
            n        <= n_inc;
            state    <= DONE;
            wd       <= '0;
          end
          DONE: begin
            done  <= 1'b1;
            en    <= EN_STOP;
            busy  <= 1'b0;
            state <= IDLE;
            wd    <= '0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            en    <= EN_STOP;
            wd    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_rd_seq.sv
// Directed bench for i2c_rd_seq: the bench plays the I2C engine one status per cycle
// and checks bus commands, read data, strobes, watchdog and reset behaviour.
module tb_i2c_rd_seq;

  localparam logic [1:0] EN_WR   = 2'd0;
  localparam logic [1:0] EN_RD   = 2'd1;
  localparam logic [1:0] EN_STOP = 2'd2;

  localparam logic [2:0] ST_Z    = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_ACK  = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_STOP = 3'd4;
  localparam logic [2:0] ST_NONE = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [4:0] len = 5'd0;
  logic       busy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       err;
  logic [7:0] data;
  logic [1:0] en;
  logic [2:0] st = ST_NONE;
  logic [7:0] out_i2c = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt = 0;
  int dcnt = 0;

  i2c_rd_seq #(.DEV_ADDR(8'hA0), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .len(len),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .data(data), .en(en), .st(st), .out_i2c(out_i2c)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_valid) vcnt++;
    if (done) dcnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic step(input logic [2:0] s);
    st = s;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] a, input logic [4:0] l);
    req = 1'b1; addr = a; len = l;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  // Request through the address write and read restart, ending in RD or RD_LAST
  task automatic header(input logic [7:0] a, input logic [4:0] l, input bit poke);
    start(a, l);
    n_cmp++;
    if ({busy, en, data} !== {1'b1, EN_WR, 8'hA0}) begin
      n_bad++; $display("FAIL dev_w: got %b/%0d/%h want 1/0/a0", busy, en, data);
    end
    if (poke) begin req = 1'b1; addr = ~a; len = 5'd3; end
    step(ST_WR);
    req = 1'b0;
    n_cmp++;
    if ({busy, en, data} !== {1'b1, EN_WR, 8'hA0}) begin
      n_bad++; $display("FAIL ack_w: got %b/%0d/%h want 1/0/a0", busy, en, data);
    end
    step(ST_ACK);
    n_cmp++;
    if ({en, data} !== {EN_WR, a}) begin
      n_bad++; $display("FAIL waddr: got en=%0d data=%h want en=0 data=%h", en, data, a);
    end
    step(ST_WR);
    n_cmp++;
    if ({en, data} !== {EN_STOP, a}) begin
      n_bad++; $display("FAIL stop_w: got en=%0d data=%h want en=2 data=%h", en, data, a);
    end
    step(ST_STOP);
    n_cmp++;
    if ({en, data} !== {EN_RD, 8'hA1}) begin
      n_bad++; $display("FAIL dev_r: got en=%0d data=%h want en=1 data=a1", en, data);
    end
    step(ST_WR);
    n_cmp++;
    if (en !== ((l > 5'd1) ? EN_RD : EN_STOP)) begin
      n_bad++; $display("FAIL dev_r_exit: got en=%0d for len=%0d", en, l);
    end
  endtask

  // Byte phase: engine supplies base, base+1, ... ; then the done cycle
  task automatic body(input logic [4:0] l, input logic [7:0] base);
    int v0;
    logic [7:0] b;
    v0 = vcnt;
    for (int i = 0; i < int'(l) - 1; i++) begin
      b = 8'(int'(base) + i);
      out_i2c = b;
      step(ST_Z);
      n_cmp++;
      if ({rd_valid, rd_data, en} !== {1'b1, b, EN_RD}) begin
        n_bad++; $display("FAIL rd_byte%0d: got v=%b d=%h en=%0d want v=1 d=%h en=1", i, rd_valid, rd_data, en, b);
      end
      step(ST_RD);
      n_cmp++;
      if ({rd_valid, en} !== {1'b0, (i == int'(l) - 2) ? EN_STOP : EN_RD}) begin
        n_bad++; $display("FAIL rd_next%0d: got v=%b en=%0d", i, rd_valid, en);
      end
    end
    b = 8'(int'(base) + int'(l) - 1);
    out_i2c = b;
    step(ST_STOP);
    n_cmp++;
    if ({rd_valid, rd_data, done, busy} !== {1'b1, b, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL rd_last: got v=%b d=%h done=%b busy=%b want 1/%h/0/1", rd_valid, rd_data, done, busy, b);
    end
    step(ST_NONE);
    n_cmp++;
    if ({done, err, busy, en, rd_valid} !== {1'b1, 1'b0, 1'b0, EN_STOP, 1'b0}) begin
      n_bad++; $display("FAIL done: got done=%b err=%b busy=%b en=%0d v=%b", done, err, busy, en, rd_valid);
    end
    step(ST_NONE);
    n_cmp++;
    if ({done, busy} !== 2'b00 || vcnt - v0 != int'(l)) begin
      n_bad++; $display("FAIL post_done: done=%b busy=%b valids=%0d want 0/0/%0d", done, busy, vcnt - v0, l);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, rd_valid, done, err, rd_data, data, en} !== {4'b0000, 8'h00, 8'h00, EN_STOP}) begin
      n_bad++; $display("FAIL reset: got busy=%b v=%b done=%b err=%b rd=%h data=%h en=%0d", busy, rd_valid, done, err, rd_data, data, en);
    end
    rst_n = 1'b1;
    step(ST_NONE);
    n_cmp++;
    if ({busy, done, en} !== {2'b00, EN_STOP}) begin
      n_bad++; $display("FAIL reset_release: got busy=%b done=%b en=%0d", busy, done, en);
    end
  endtask

  task automatic test_single;
    header(8'h00, 5'd1, 1'b0);
    body(5'd1, 8'h96);
  endtask

  task automatic test_seq;
    header(8'h00, 5'd16, 1'b0);
    body(5'd16, 8'h96);
  endtask

  task automatic test_loop;
    for (int i = 0; i < 16; i++) begin
      header(8'(i), 5'd1, 1'b0);
      body(5'd1, 8'(i + 'h96));
    end
  endtask

  task automatic test_invalid;
    logic [4:0] bad [2];
    bad[0] = 5'd0;
    bad[1] = 5'd17;
    for (int k = 0; k < 2; k++) begin
      start(8'h33, bad[k]);
      n_cmp++;
      if ({done, err, en, busy} !== {1'b1, 1'b1, EN_STOP, 1'b0}) begin
        n_bad++; $display("FAIL invalid_len%0d: got done=%b err=%b en=%0d busy=%b", bad[k], done, err, en, busy);
      end
      step(ST_NONE);
      n_cmp++;
      if ({done, err, busy} !== 3'b000) begin
        n_bad++; $display("FAIL invalid_after%0d: got done=%b err=%b busy=%b", bad[k], done, err, busy);
      end
    end
  endtask

  task automatic test_busy_req;
    header(8'h22, 5'd2, 1'b1);
    body(5'd2, 8'h40);
    step(ST_NONE);
    n_cmp++;
    if ({busy, en} !== {1'b0, EN_STOP}) begin
      n_bad++; $display("FAIL busy_req_queued: got busy=%b en=%0d want 0/2", busy, en);
    end
  endtask

  task automatic test_timeout;
    int cyc;
    start(8'h44, 5'd4);
    step(ST_WR);
    st = ST_NONE;
    cyc = 0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL timeout_busy: got busy=%b want 1", busy);
    end
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != 64) begin
      n_bad++; $display("FAIL timeout_cycles: got %0d want 64", cyc);
    end
    n_cmp++;
    if ({done, err, en, busy} !== {1'b1, 1'b1, EN_STOP, 1'b0}) begin
      n_bad++; $display("FAIL timeout_outputs: got done=%b err=%b en=%0d busy=%b", done, err, en, busy);
    end
    step(ST_NONE);
    n_cmp++;
    if ({done, err} !== 2'b00) begin
      n_bad++; $display("FAIL timeout_pulse: got done=%b err=%b want 0/0", done, err);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    header(8'h10, 5'd8, 1'b0);
    out_i2c = 8'h50;
    step(ST_Z);
    n_cmp++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h50}) begin
      n_bad++; $display("FAIL mid_byte: got v=%b d=%h want 1/50", rd_valid, rd_data);
    end
    step(ST_RD);
    d0 = dcnt;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, rd_valid, done, err, rd_data, data, en} !== {4'b0000, 8'h00, 8'h00, EN_STOP}) begin
      n_bad++; $display("FAIL mid_reset: got busy=%b v=%b done=%b err=%b rd=%h data=%h en=%0d", busy, rd_valid, done, err, rd_data, data, en);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(ST_NONE);
    step(ST_NONE);
    n_cmp++;
    if (dcnt != d0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_no_done: done pulses %0d busy=%b want 0/0", dcnt - d0, busy);
    end
    header(8'h05, 5'd1, 1'b0);
    body(5'd1, 8'h9B);
  endtask

  initial begin
    test_reset;
    test_single;
    test_seq;
    test_loop;
    test_invalid;
    test_busy_req;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
